// File: rtl/async_fifo_rd_stream_pkg.sv
// Shared definitions for the async FIFO read-side stream adapter:
// controller state encoding and output queue geometry.
package async_fifo_rd_stream_pkg;

    localparam int unsigned QUEUE_DEPTH = 2;
    localparam int unsigned OCC_W       = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FLUSH  = 2'd2
    } state_e;

endpackage

// File: rtl/async_fifo_rd_stream_queue2.sv
// Two-entry in-order output queue with registered head data and valid.
// Supports simultaneous push and pop, plus a clear that empties it.
module stream_queue2
    import async_fifo_rd_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [OCC_W-1:0]      occ,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] head
);

    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [OCC_W-1:0]      occ_q, occ_d;
    logic                  valid_q, valid_d;

    // Next queue contents; pop is only ever requested while the queue holds a word.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (clear) begin
            occ_d = '0;
        end else begin
            case ({push, pop})
                2'b11: begin
                    if (occ_q == OCC_W'(QUEUE_DEPTH)) begin
                        head_d = tail_q;
                        tail_d = push_data;
                    end else begin
                        head_d = push_data;
                    end
                end
                2'b10: begin
                    if (occ_q == '0) begin
                        head_d = push_data;
                    end else begin
                        tail_d = push_data;
                    end
                    occ_d = occ_q + OCC_W'(1);
                end
                2'b01: begin
                    head_d = tail_q;
                    occ_d  = occ_q - OCC_W'(1);
                end
                default: ;
            endcase
        end
        valid_d = (occ_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            occ_q   <= occ_d;
            valid_q <= valid_d;
        end
    end

    assign occ   = occ_q;
    assign valid = valid_q;
    assign head  = head_q;

    // A word landing into a full queue would be lost; the pop rule upstream prevents it.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && !clear && occ_q == OCC_W'(QUEUE_DEPTH)));

endmodule

// File: rtl/async_fifo_rd_stream.sv
// Read-domain consumer for async_fifo: pops the FIFO, hides its one-cycle read
// latency behind a 2-entry queue, and presents a valid/ready stream with flush.
module async_fifo_rd_stream
    import async_fifo_rd_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  flush,
    output logic                  flush_done,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic [CNT_WIDTH-1:0]  drop_count
);

    state_e               state_q, state_d;
    logic                 inflight_q, inflight_d;
    logic                 flush_done_q, flush_done_d;
    logic [CNT_WIDTH-1:0] word_count_q, word_count_d;
    logic [CNT_WIDTH-1:0] drop_count_q, drop_count_d;

    logic [OCC_W-1:0]     occ;
    logic [OCC_W-1:0]     occ_nxt;
    logic [2:0]           pending;
    logic                 hs;
    logic                 in_flush;
    logic                 flush_enter;
    logic                 q_push;

    assign in_flush    = (state_q == ST_FLUSH);
    assign hs          = m_valid & m_ready;
    assign flush_enter = flush & ~in_flush;

    // Words owned by this block after this cycle's handshake: buffered plus landing.
    assign pending    = 3'(occ) + 3'(inflight_q) - 3'(hs);
    assign fifo_rd_en = ~rst & ~fifo_empty & (in_flush | (pending < 3'(QUEUE_DEPTH)));

    // Landed words are kept only outside of a flush.
    assign q_push  = inflight_q & ~in_flush & ~flush;
    assign occ_nxt = occ + OCC_W'(q_push) - OCC_W'(hs);

    stream_queue2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush_enter),
        .push      (q_push),
        .push_data (fifo_rd_data),
        .pop       (hs),
        .occ       (occ),
        .valid     (m_valid),
        .head      (m_data)
    );

    // Controller next state, landing tracker and counters.
    always_comb begin
        state_d      = state_q;
        inflight_d   = fifo_rd_en;
        flush_done_d = 1'b0;
        word_count_d = word_count_q + CNT_WIDTH'(hs);
        drop_count_d = drop_count_q;
        case (state_q)
            ST_FLUSH: begin
                drop_count_d = drop_count_q + CNT_WIDTH'(inflight_q);
                if (fifo_empty && !inflight_q && !flush) begin
                    state_d      = ST_IDLE;
                    flush_done_d = 1'b1;
                end
            end
            default: begin
                if (flush) begin
                    // Everything buffered or landing now is discarded; a delivered word is not.
                    state_d      = ST_FLUSH;
                    drop_count_d = drop_count_q + CNT_WIDTH'(pending);
                end else if (occ_nxt != '0 || fifo_rd_en) begin
                    state_d = ST_ACTIVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            inflight_q   <= 1'b0;
            flush_done_q <= 1'b0;
            word_count_q <= '0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            inflight_q   <= inflight_d;
            flush_done_q <= flush_done_d;
            word_count_q <= word_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign flush_done = flush_done_q;
    assign word_count = word_count_q;
    assign drop_count = drop_count_q;

endmodule
